random_interval_timer: RTL and testbench
========================================

Name: random_interval_timer

Overview:
- Consumer stage directly downstream of the 16-bit LFSR pseudo-random generator.
- On request, samples the generator's current output and maps it into a bounded tick count [MIN_TICKS, MAX_TICKS].
- Counts that interval down at a prescaled tick rate, then emits a one-cycle expiry pulse.
- Used for randomized game/event delays (e.g. reaction-time prompts, LED blink jitter).

Parameters:
- RAND_W, 16: width of the random input; must match the generator output.
- CNT_W, 16: width of the tick counter and of the remaining output.
- MIN_TICKS, 10: minimum interval in ticks; must be >= 1.
- MAX_TICKS, 1009: maximum interval in ticks; must be >= MIN_TICKS and < 2**CNT_W.
- PRESCALE, 1000: clock cycles per tick; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rand_num  in  RAND_W  current generator value; sampled only on start acceptance.
- start  in  1  request a new interval; accepted when start && ready.
- cancel  in  1  abort the running interval.
- ready  out  1  high in IDLE; able to accept start.
- busy  out  1  high in LOAD or COUNT.
- expired  out  1  one-cycle pulse when the interval ends naturally.
- remaining  out  CNT_W  ticks left; 0 when not counting.

Behaviour:
- Reset (synchronous): state=IDLE, ready=1, busy=0, expired=0, remaining=0, prescale counter=0, rand_q=0.
- State machine (states in package enum):
  - IDLE -> LOAD on start && !cancel.
  - LOAD -> COUNT unconditionally.
  - COUNT -> IDLE on final tick or on cancel.
- Cycle N (IDLE, start accepted): rand_q <= rand_num.
- Cycle N+1 (LOAD): remaining <= MIN_TICKS + ((rand_q * SPAN) >> RAND_W), where SPAN = MAX_TICKS - MIN_TICKS + 1.
  - Full RAND_W+CNT_W+1-bit product, truncated by shift.
  - No modulo; result is always within [MIN_TICKS, MAX_TICKS].
  - Prescale counter cleared.
- COUNT:
  - Prescale counter runs 0..PRESCALE-1 and wraps.
  - Tick occurs when counter == PRESCALE-1; on a tick, remaining decrements.
  - Tick where remaining == 1: remaining <= 0, state <= IDLE, expired <= 1 (registered).
  - COUNT lasts exactly delay*PRESCALE cycles.
- Latency: expired is high at cycle N+2+delay*PRESCALE, and ready=1 in that same cycle.
- expired is high for exactly one cycle.
- Back-to-back: start during the expired cycle is accepted; that cycle is cycle N of the next interval.
- start while busy: ignored; no effect on the running interval.
- cancel in LOAD or COUNT: next cycle state=IDLE, remaining=0, expired stays 0.
- cancel and final tick in the same cycle: cancel wins; no expired pulse.
- start and cancel together in IDLE: cancel wins; start is not accepted.
- PRESCALE == 1: a tick occurs every COUNT cycle.
- rst asserted mid-interval: all reset values apply on the next edge; no expired pulse.
- Elaboration-time assertions check the parameter legality rules above.

Decomposition:
- Package prng_pkg holds:
  - RAND_W default constant.
  - timer_state_t enum {IDLE, LOAD, COUNT}.
  - Function scale_interval(rand, min, max) implementing the multiply-shift mapping, shared by RTL and the bench model.
- One sub-module, tick_prescaler:
  - Ports: clk, rst, clr, en, tick.
  - Parameter: PRESCALE.
  - Synchronous clear; tick is a single-cycle pulse.

Test Plan (bench parameters MIN_TICKS=2, MAX_TICKS=5, PRESCALE=3; SPAN=4, so delay = 2 + rand_num[15:14]):
- After rst, rand_num=16'h0F0F, start pulse at cycle 0 -> LOAD sets remaining=2; expired high only at cycle 8; ready low in cycles 1-7.
- rand_num=16'hC000, start -> remaining=5; expired at cycle 17; remaining decrements every 3 cycles (5,4,3,2,1,0).
- Count running, cancel asserted while remaining=3 -> next cycle remaining=0, ready=1, no expired pulse ever follows.
- start held high continuously with rand_num=16'h4000 (delay 3) -> expired every 11 cycles (3*3+2); each expired cycle also accepts the next start.
- start while busy, plus simultaneous start+cancel in IDLE -> neither disturbs the running interval nor leaves IDLE; rst asserted mid-count -> all outputs return to reset values on the next edge.
- Random regression: 1000 intervals with the LFSR as the source -> remaining at LOAD always in [2,5] and equal to scale_interval(); measured latency = delay*3+2.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and the random-to-interval mapping used by the interval timer and its bench.
package prng_pkg;

    parameter int RAND_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2
    } timer_state_t;

    // Multiply-shift mapping: scales randVal/2^RAND_W onto [minTicks, maxTicks] without a modulo.
    function automatic int unsigned scale_interval(
        input logic [RAND_W-1:0] randVal,
        input int unsigned       minTicks,
        input int unsigned       maxTicks
    );
        longint unsigned span;
        longint unsigned product;
        span    = 64'(maxTicks) - 64'(minTicks) + 64'd1;
        product = 64'(randVal) * span;
        return 32'(64'(minTicks) + (product >> RAND_W));
    endfunction

endpackage

// File: rtl/random_interval_timer_if.sv
// Request/status bundle between a random-interval consumer and its controller.
interface random_interval_timer_if #(
    parameter int RAND_W = 16,
    parameter int CNT_W  = 16
);
    logic [RAND_W-1:0] rand_num;
    logic              start;
    logic              cancel;
    logic              ready;
    logic              busy;
    logic              expired;
    logic [CNT_W-1:0]  remaining;

    modport master (
        output rand_num, start, cancel,
        input  ready, busy, expired, remaining
    );

    modport slave (
        input  rand_num, start, cancel,
        output ready, busy, expired, remaining
    );
endinterface

// File: rtl/tick_prescaler.sv
// Divides the clock into one-cycle tick pulses, one every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] r_count;
    logic          w_atTop;

    assign w_atTop = (r_count == CW'(PRESCALE - 1));
    assign tick    = en && w_atTop;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_atTop ? '0 : r_count + CW'(1);
        end
    end
endmodule

// File: rtl/random_interval_timer.sv
// Samples a random value on request, maps it to a bounded tick count and
// counts it down at the prescaled rate, pulsing expired when it runs out.
module random_interval_timer
    import prng_pkg::*;
#(
    parameter int RAND_W    = prng_pkg::RAND_W,
    parameter int CNT_W     = 16,
    parameter int MIN_TICKS = 10,
    parameter int MAX_TICKS = 1009,
    parameter int PRESCALE  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    random_interval_timer_if.slave bus
);
    generate
        if (MIN_TICKS < 1) begin : gBadMin
            $error("MIN_TICKS must be >= 1");
        end
        if (MAX_TICKS < MIN_TICKS) begin : gBadMax
            $error("MAX_TICKS must be >= MIN_TICKS");
        end
        if (longint'(MAX_TICKS) >= (longint'(1) << CNT_W)) begin : gBadCntW
            $error("MAX_TICKS must fit in CNT_W bits");
        end
        if (PRESCALE < 1) begin : gBadPrescale
            $error("PRESCALE must be >= 1");
        end
        if (RAND_W != prng_pkg::RAND_W) begin : gBadRandW
            $error("RAND_W must match the generator width in prng_pkg");
        end
    endgenerate

    timer_state_t      r_state;
    timer_state_t      w_nextState;
    logic [RAND_W-1:0] r_randQ;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_expired;
    logic              w_accept;
    logic              w_tick;
    logic              w_lastTick;
    logic              w_ready;
    logic              w_busy;
    logic              w_clrPrescale;
    logic              w_enPrescale;
    logic [CNT_W-1:0]  w_loadValue;

    assign w_accept      = (r_state == IDLE) && bus.start && !bus.cancel;
    assign w_lastTick    = (r_state == COUNT) && w_tick && (r_remaining == CNT_W'(1));
    assign w_loadValue   = CNT_W'(scale_interval(r_randQ, MIN_TICKS, MAX_TICKS));
    assign w_clrPrescale = (r_state == LOAD);
    assign w_enPrescale  = (r_state == COUNT);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (w_clrPrescale),
        .en  (w_enPrescale),
        .tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Cancel takes priority over both the LOAD step and the final tick.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = LOAD;
            LOAD:    w_nextState = bus.cancel ? IDLE : COUNT;
            COUNT:   if (bus.cancel || w_lastTick) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == IDLE);
        w_busy  = (r_state == LOAD) || (r_state == COUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_randQ     <= '0;
            r_remaining <= '0;
            r_expired   <= 1'b0;
        end else begin
            r_expired <= w_lastTick && !bus.cancel;
            if (w_accept) begin
                r_randQ <= bus.rand_num;
            end
            case (r_state)
                LOAD:    r_remaining <= bus.cancel ? '0 : w_loadValue;
                COUNT: begin
                    if (bus.cancel) begin
                        r_remaining <= '0;
                    end else if (w_tick) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: r_remaining <= '0;
            endcase
        end
    end

    assign bus.ready     = w_ready;
    assign bus.busy      = w_busy;
    assign bus.expired   = r_expired;
    assign bus.remaining = r_remaining;
endmodule

// File: tb/tb_random_interval_timer.sv
// Randomized self-checking bench for random_interval_timer with a cycle-offset reference model.
module tb_random_interval_timer;
    import prng_pkg::*;

    localparam int MIN_T = 2;
    localparam int MAX_T = 5;
    localparam int PRE   = 3;
    localparam int RW    = 16;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    random_interval_timer_if #(.RAND_W(RW), .CNT_W(CW)) bus ();

    random_interval_timer #(
        .RAND_W   (RW),
        .CNT_W    (CW),
        .MIN_TICKS(MIN_T),
        .MAX_TICKS(MAX_T),
        .PRESCALE (PRE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    string       phase       = "init";
    logic [15:0] lfsr;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic c, input logic [15:0] r);
        bus.start    = s;
        bus.cancel   = c;
        bus.rand_num = r;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s [%s]: got %0d, expected %0d", tag, phase, observed, expected);
        end
    endtask

    task automatic checkState(input bit expR, input bit expB, input bit expE, input int expRem);
        checkOutput("ready", int'(bus.ready), int'(expR));
        checkOutput("busy", int'(bus.busy), int'(expB));
        checkOutput("expired", int'(bus.expired), int'(expE));
        checkOutput("remaining", int'(bus.remaining), expRem);
    endtask

    // Offset t counts cycles since the start-acceptance cycle; the model is pure arithmetic on t.
    task automatic runInterval(input string name, input logic [15:0] r, input int cancelAt, input bit noise);
        int d;
        int total;
        d     = int'(scale_interval(r, MIN_T, MAX_T));
        total = d * PRE + 2;
        phase = name;
        checkOutput("readyAtStart", int'(bus.ready), 1);
        applyStimulus(1'b1, 1'b0, r);
        for (int t = 1; t <= total + 2; t++) begin
            bit idle;
            bit expE;
            int expRem;
            stepCycle();
            phase = $sformatf("%s t=%0d", name, t);
            if (cancelAt > 0 && t > cancelAt) begin
                idle = 1'b1; expE = 1'b0; expRem = 0;
            end else if (t < total) begin
                idle = 1'b0; expE = 1'b0;
                expRem = (t == 1) ? 0 : d - (t - 2) / PRE;
            end else begin
                idle = 1'b1; expE = (t == total); expRem = 0;
            end
            checkState(idle, !idle, expE, expRem);
            applyStimulus(noise && !idle, (t == cancelAt), noise ? 16'($urandom) : r);
        end
        applyStimulus(1'b0, 1'b0, r);
    endtask

    task automatic measureInterval(input logic [15:0] r);
        int  cycles;
        int  remAtLoad;
        int  d;
        bit  seen;
        d         = int'(scale_interval(r, MIN_T, MAX_T));
        cycles    = 0;
        remAtLoad = -1;
        seen      = 1'b0;
        phase     = $sformatf("regress r=%h", r);
        applyStimulus(1'b1, 1'b0, r);
        stepCycle();
        cycles = 1;
        applyStimulus(1'b0, 1'b0, 16'($urandom));
        while (!seen && cycles < 100) begin
            stepCycle();
            cycles++;
            if (cycles == 2) remAtLoad = int'(bus.remaining);
            if (bus.expired) seen = 1'b1;
        end
        checkOutput("expiredSeen", int'(seen), 1);
        checkOutput("remInRange", int'(remAtLoad >= MIN_T && remAtLoad <= MAX_T), 1);
        checkOutput("remAtLoad", remAtLoad, d);
        checkOutput("latency", cycles, d * PRE + 2);
    endtask

    initial begin
        bit sawExpired;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0);
        stepCycle();
        stepCycle();
        phase = "reset";
        checkState(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        stepCycle();
        checkState(1'b1, 1'b0, 1'b0, 0);

        runInterval("basic0F0F", 16'h0F0F, 0, 1'b0);
        runInterval("basicC000", 16'hC000, 0, 1'b0);
        runInterval("cancelRem3", 16'hC000, 8, 1'b0);
        runInterval("cancelLoad", 16'h8000, 1, 1'b0);
        runInterval("cancelFinalTick", 16'h0F0F, 7, 1'b0);
        runInterval("startWhileBusy", 16'h4000, 0, 1'b1);

        // Start held high: every expired cycle doubles as the next acceptance cycle.
        phase = "heldStart";
        applyStimulus(1'b1, 1'b0, 16'h4000);
        for (int t = 1; t <= 33; t++) begin
            int ph;
            int expRem;
            stepCycle();
            phase = $sformatf("heldStart t=%0d", t);
            ph = t % 11;
            expRem = (ph == 0 || ph == 1) ? 0 : 3 - (ph - 2) / PRE;
            checkState(ph == 0, ph != 0, ph == 0, expRem);
            if (t == 33) applyStimulus(1'b0, 1'b0, 16'h4000);
        end
        stepCycle();
        phase = "heldStartEnd";
        checkState(1'b1, 1'b0, 1'b0, 0);

        phase = "startCancelIdle";
        applyStimulus(1'b1, 1'b1, 16'hC000);
        stepCycle();
        checkState(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 16'hC000);
        stepCycle();
        checkState(1'b1, 1'b0, 1'b0, 0);

        phase = "midReset";
        applyStimulus(1'b1, 1'b0, 16'hC000);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 16'hC000);
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("remBeforeReset", int'(bus.remaining), 4);
        rst = 1'b1;
        stepCycle();
        checkState(1'b1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        sawExpired = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (bus.expired) sawExpired = 1'b1;
        end
        checkOutput("noExpiredAfterReset", int'(sawExpired), 0);

        lfsr = 16'($urandom_range(1, 65535));
        for (int i = 0; i < 1000; i++) begin
            int gap;
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) stepCycle();
            measureInterval(lfsr);
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
